// File: rtl/lcd_text_feeder_pkg.sv
// Shared constants, state encoding and byte helpers for the LCD text feeder.
package lcd_text_feeder_pkg;

  // HD44780-style command bytes
  localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM  = 8'h80;

  // DDRAM base address of each visible row
  localparam logic [7:0] ROW0_BASE = 8'h00;
  localparam logic [7:0] ROW1_BASE = 8'h40;

  // Control codes recognised in the text stream
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  localparam int INIT_LEN = 4;

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT_ISSUE,
    INIT_ACK,
    IDLE,
    ISSUE,
    ACK,
    WRAP_ISSUE,
    WRAP_ACK
  } feeder_state_t;

  typedef enum logic [2:0] {
    BYTE_PRINT,
    BYTE_CR,
    BYTE_LF,
    BYTE_FF,
    BYTE_OTHER
  } byte_class_t;

  function automatic byte_class_t classify_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) return BYTE_PRINT;
    else if (b == CODE_CR)        return BYTE_CR;
    else if (b == CODE_LF)        return BYTE_LF;
    else if (b == CODE_FF)        return BYTE_FF;
    else                          return BYTE_OTHER;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNC_SET;
      2'd1:    return LCD_CMD_ENTRY_MODE;
      2'd2:    return LCD_CMD_DISPLAY_ON;
      default: return LCD_CMD_CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic row);
    return row ? ROW1_BASE : ROW0_BASE;
  endfunction

  // Set-DDRAM-address command for a cursor position
  function automatic logic [7:0] ddram_cmd(input logic row, input logic [7:0] col);
    return LCD_CMD_SET_DDRAM | (row_base(row) + col);
  endfunction

endpackage

// File: rtl/lcd_text_feeder_if.sv
// Byte-stream input and LCD writer handshake bundle.
// master = the feeder itself, slave = upstream source plus downstream writer.
interface lcd_text_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wreq;
  logic       wack;
  logic       wregister;
  logic [7:0] wvalue;

  modport master (
    input  in_data, in_valid, wack,
    output in_ready, wreq, wregister, wvalue
  );

  modport slave (
    output in_data, in_valid, wack,
    input  in_ready, wreq, wregister, wvalue
  );
endinterface

// File: rtl/lcd_byte_fifo.sv
// Small synchronous FIFO buffering text bytes ahead of the LCD sequencer.
module lcd_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; push+pop together leaves the count unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_feeder.sv
// Turns a text byte stream into LCD writer transactions: power-on wait,
// init command sequence, then data writes with cursor tracking and wrap.
//
// state      | meaning
// POR_WAIT   | counting the power-on delay, no writes
// INIT_ISSUE | wreq high for an init command
// INIT_ACK   | waiting for wack of an init command
// IDLE       | waiting for a byte in the FIFO
// ISSUE      | wreq high for a text data/command write
// ACK        | waiting for wack of a text write
// WRAP_ISSUE | wreq high for the line-wrap cursor move
// WRAP_ACK   | waiting for wack of the line-wrap move
module lcd_text_feeder
  import lcd_text_feeder_pkg::*;
#(
  parameter int POR_CYCLES = 750000,
  parameter int COLS       = 16,
  parameter int ROWS       = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  lcd_text_feeder_if.master bus,
  output logic              init_done
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;

  feeder_state_t    r_state;
  feeder_state_t    w_state_nxt;
  logic [POR_W-1:0] r_por_cnt;
  logic [POR_W-1:0] w_por_cnt_nxt;
  logic [1:0]       r_init_idx;
  logic [1:0]       w_init_idx_nxt;
  logic             r_row;
  logic             w_row_nxt;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_nxt;
  logic             r_wreq;
  logic             w_wreq_nxt;
  logic             r_wregister;
  logic             w_wregister_nxt;
  logic [7:0]       r_wvalue;
  logic [7:0]       w_wvalue_nxt;
  logic             r_init_done;
  logic             w_init_done_nxt;
  logic             r_ready_en;

  logic             w_pop;
  logic             w_push;
  logic [7:0]       w_fifo_data;
  logic             w_full;
  logic             w_empty;
  logic             w_row_adv;
  logic [COL_W-1:0] w_col_inc;

  // in_ready is held low during reset and opens on the first clock after it.
  assign bus.in_ready  = r_ready_en & ~w_full;
  assign bus.wreq      = r_wreq;
  assign bus.wregister = r_wregister;
  assign bus.wvalue    = r_wvalue;
  assign init_done     = r_init_done;

  assign w_push    = bus.in_valid & bus.in_ready;
  assign w_row_adv = (ROWS == 2) ? ~r_row : 1'b0;
  assign w_col_inc = r_col + COL_W'(1);

  lcd_byte_fifo #(
    .DEPTH (4),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (bus.in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State, cursor and registered write-port outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= POR_WAIT;
      r_por_cnt   <= '0;
      r_init_idx  <= '0;
      r_row       <= 1'b0;
      r_col       <= '0;
      r_wreq      <= 1'b0;
      r_wregister <= 1'b0;
      r_wvalue    <= 8'h00;
      r_init_done <= 1'b0;
      r_ready_en  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_por_cnt   <= w_por_cnt_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_wreq      <= w_wreq_nxt;
      r_wregister <= w_wregister_nxt;
      r_wvalue    <= w_wvalue_nxt;
      r_init_done <= w_init_done_nxt;
      r_ready_en  <= 1'b1;
    end
  end

  // Next-state logic; a write is launched on the edge that enters an *_ISSUE state.
  always_comb begin
    w_state_nxt     = r_state;
    w_por_cnt_nxt   = r_por_cnt;
    w_init_idx_nxt  = r_init_idx;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_wreq_nxt      = 1'b0;
    w_wregister_nxt = r_wregister;
    w_wvalue_nxt    = r_wvalue;
    w_init_done_nxt = r_init_done;
    w_pop           = 1'b0;

    case (r_state)
      POR_WAIT: begin
        if (r_por_cnt == POR_W'(POR_CYCLES - 1)) begin
          w_state_nxt     = INIT_ISSUE;
          w_init_idx_nxt  = 2'd0;
          w_wreq_nxt      = 1'b1;
          w_wregister_nxt = 1'b0;
          w_wvalue_nxt    = init_cmd(2'd0);
        end else begin
          w_por_cnt_nxt = r_por_cnt + POR_W'(1);
        end
      end

      INIT_ISSUE: w_state_nxt = INIT_ACK;

      INIT_ACK: begin
        if (bus.wack) begin
          if (r_init_idx == 2'(INIT_LEN - 1)) begin
            w_state_nxt     = IDLE;
            w_init_done_nxt = 1'b1;
            w_row_nxt       = 1'b0;
            w_col_nxt       = '0;
          end else begin
            w_state_nxt     = INIT_ISSUE;
            w_init_idx_nxt  = r_init_idx + 2'd1;
            w_wreq_nxt      = 1'b1;
            w_wregister_nxt = 1'b0;
            w_wvalue_nxt    = init_cmd(r_init_idx + 2'd1);
          end
        end
      end

      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (classify_byte(w_fifo_data))
            BYTE_PRINT: begin
              w_state_nxt     = ISSUE;
              w_wreq_nxt      = 1'b1;
              w_wregister_nxt = 1'b1;
              w_wvalue_nxt    = w_fifo_data;
            end
            BYTE_CR: begin
              w_state_nxt     = ISSUE;
              w_col_nxt       = '0;
              w_wreq_nxt      = 1'b1;
              w_wregister_nxt = 1'b0;
              w_wvalue_nxt    = ddram_cmd(r_row, 8'h00);
            end
            BYTE_LF: begin
              w_state_nxt     = ISSUE;
              w_row_nxt       = w_row_adv;
              w_wreq_nxt      = 1'b1;
              w_wregister_nxt = 1'b0;
              w_wvalue_nxt    = ddram_cmd(w_row_adv, 8'(r_col));
            end
            BYTE_FF: begin
              w_state_nxt     = ISSUE;
              w_row_nxt       = 1'b0;
              w_col_nxt       = '0;
              w_wreq_nxt      = 1'b1;
              w_wregister_nxt = 1'b0;
              w_wvalue_nxt    = LCD_CMD_CLEAR;
            end
            default: w_state_nxt = IDLE;
          endcase
        end
      end

      ISSUE: w_state_nxt = ACK;

      // Column advances only once the data write is acknowledged.
      ACK: begin
        if (bus.wack) begin
          if (r_wregister) begin
            if (w_col_inc == COL_W'(COLS)) begin
              w_state_nxt     = WRAP_ISSUE;
              w_row_nxt       = w_row_adv;
              w_col_nxt       = '0;
              w_wreq_nxt      = 1'b1;
              w_wregister_nxt = 1'b0;
              w_wvalue_nxt    = ddram_cmd(w_row_adv, 8'h00);
            end else begin
              w_state_nxt = IDLE;
              w_col_nxt   = w_col_inc;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      WRAP_ISSUE: w_state_nxt = WRAP_ACK;

      WRAP_ACK: begin
        if (bus.wack) w_state_nxt = IDLE;
      end

      default: w_state_nxt = POR_WAIT;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Randomised self-checking bench for lcd_text_feeder against a cursor-level model.
module tb_lcd_text_feeder;

  localparam int POR  = 8;
  localparam int COLS = 16;
  localparam int ROWS = 2;

  logic clock;
  logic reset_n;
  logic init_done;

  lcd_text_feeder_if bus();

  lcd_text_feeder #(
    .POR_CYCLES (POR),
    .COLS       (COLS),
    .ROWS       (ROWS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .init_done (init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // expected writes, {wregister, wvalue}
  bit [8:0] exp_q[$];
  int       m_row;
  int       m_col;

  bit       mon_pending;
  bit [8:0] mon_lat;
  bit [8:0] mon_e;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  function automatic bit [7:0] base_of(input int r);
    return (r != 0) ? 8'h40 : 8'h00;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    m_row = 0;
    m_col = 0;
  endfunction

  // What the display must receive for one accepted byte
  function automatic void model_byte(input bit [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({1'b1, b});
      m_col++;
      if (m_col == COLS) begin
        m_row = (m_row + 1) % ROWS;
        m_col = 0;
        exp_q.push_back({1'b0, 8'h80 | base_of(m_row)});
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
      exp_q.push_back({1'b0, 8'h80 | base_of(m_row)});
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
      exp_q.push_back({1'b0, 8'h80 | (base_of(m_row) + 8'(m_col))});
    end else if (b == 8'h0C) begin
      exp_q.push_back({1'b0, 8'h01});
      m_row = 0;
      m_col = 0;
    end
  endfunction

  function automatic bit [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70)      return 8'($urandom_range(32, 126));
    else if (r < 77) return 8'h0D;
    else if (r < 84) return 8'h0A;
    else if (r < 88) return 8'h0C;
    else             return 8'($urandom_range(0, 255));
  endfunction

  // Writer model: wack three cycles after each wreq
  initial begin
    bus.wack = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      while (bus.wreq) begin
        repeat (3) @(posedge clock);
        #1 bus.wack = 1'b1;
        @(posedge clock);
        #1 bus.wack = 1'b0;
      end
    end
  end

  // Write monitor: order/content against the model, stability through wack
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_pending = 1'b0;
    end else if (bus.wreq) begin
      check("wreq_before_ack", mon_pending, 1'b0);
      check("write_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("write_reg", bus.wregister, mon_e[8]);
        check("write_val", bus.wvalue, mon_e[7:0]);
        mon_lat     = mon_e;
        mon_pending = 1'b1;
      end else begin
        mon_pending = 1'b0;
      end
    end else if (mon_pending && bus.wack) begin
      check("hold_stable", {bus.wregister, bus.wvalue}, mon_lat);
      mon_pending = 1'b0;
    end
  end

  task automatic push_byte(input bit [7:0] b);
    int t;
    t = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (!bus.in_ready) begin
      check("push_accept", bus.in_ready, 1'b1);
    end else begin
      @(posedge clock);
      model_byte(b);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    repeat (20) @(negedge clock);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_wreq"}, bus.wreq, 1'b0);
    check({tag, "_wregister"}, bus.wregister, 1'b0);
    check({tag, "_wvalue"}, bus.wvalue, 8'h00);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
  endtask

  // Entered at the negedge where reset_n was released; holds in_valid high through POR
  task automatic por_phase();
    int  acc;
    int  first;
    bit  take;
    acc   = 0;
    first = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom_range(32, 126));
    for (int c = 1; c <= 12; c++) begin
      take = bus.in_ready && bus.in_valid;
      @(posedge clock);
      if (take) begin
        model_byte(bus.in_data);
        acc++;
      end
      @(negedge clock);
      if (take) bus.in_data = 8'($urandom_range(32, 126));
      if (bus.wreq && first < 0) first = c;
      if (c == 1) check("in_ready_after_release", bus.in_ready, 1'b1);
      if (c == 7) begin
        check("por_accepted", acc, 4);
        check("por_in_ready_full", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
      end
      if (c == 12) check("init_done_mid_init", init_done, 1'b0);
    end
    check("por_first_wreq_cycle", (first >= POR && first <= POR + 1), 1'b1);
  endtask

  initial begin
    int t;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    reset_outputs("reset");

    reset_n = 1'b1;
    por_phase();
    drain("drain_init");
    check("init_done_high", init_done, 1'b1);

    push_byte(8'h48);
    push_byte(8'h69);
    drain("drain_hi");

    push_byte(8'h0C);
    for (int i = 0; i < 17; i++) push_byte(8'($urandom_range(32, 126)));
    drain("drain_wrap");

    push_byte(8'h0C);
    push_byte(8'h41);
    push_byte(8'h0A);
    push_byte(8'h0D);
    push_byte(8'h0C);
    push_byte(8'h07);
    drain("drain_ctrl");

    for (int i = 0; i < 200; i++) begin
      push_byte(rand_byte());
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain("drain_random");

    // Reset in the middle of a handshake
    push_byte(8'h55);
    t = 0;
    while (!bus.wreq && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("mid_wreq_seen", bus.wreq, 1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    reset_outputs("mid_reset");
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    por_phase();
    drain("drain_reinit");
    check("reinit_done", init_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
